// File: rtl/imem_dmem_arbiter.sv
// Arbitrates the fetch and memory stages onto one unified memory port.
// Define ARB_RR_EN for round-robin on simultaneous requests (default: data first).
module imem_dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_rvalid,
    output logic              stall_if,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_rvalid,
    output logic [1:0]        proc2mem_command,
    output logic [ADDR_W-1:0] proc2mem_addr,
    output logic [DATA_W-1:0] proc2mem_data,
    input  logic              mem2proc_ack,
    input  logic [DATA_W-1:0] mem2proc_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;

    state_t            state;
    state_t            state_nxt;
    logic              drop;
    logic              drop_nxt;
    logic [1:0]        cmd_q;
    logic [1:0]        cmd_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_nxt;
    logic              if_gnt_c;
    logic              dm_gnt_c;
    logic              if_rvalid_c;
    logic              dm_rvalid_c;
    logic              fetch_ok;
    logic              pick_dm;
    logic              pick_if;
    logic [ADDR_W-1:0] if_addr_al;
    logic [ADDR_W-1:0] dm_addr_al;

    // Byte-offset bits are dropped on purpose; the memory is word addressed.
    logic unused_ok;
    assign unused_ok = &{1'b0, if_addr[1:0], dm_addr[1:0]};

    assign if_addr_al = {if_addr[ADDR_W-1:2], 2'b00};
    assign dm_addr_al = {dm_addr[ADDR_W-1:2], 2'b00};

    // A flush in IDLE means the presented PC is stale; skip it for that cycle.
    assign fetch_ok = if_req & ~if_flush;

`ifdef ARB_RR_EN
    logic last_dm;
    logic last_dm_nxt;

    assign pick_dm = dm_req & ~(fetch_ok & last_dm);
    assign pick_if = fetch_ok & ~pick_dm;

    always_comb begin
        last_dm_nxt = last_dm;
        if (dm_gnt_c) begin
            last_dm_nxt = 1'b1;
        end else if (if_gnt_c) begin
            last_dm_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dm <= 1'b1;
        end else begin
            last_dm <= last_dm_nxt;
        end
    end
`else
    assign pick_dm = dm_req;
    assign pick_if = fetch_ok & ~dm_req;
`endif

    always_comb begin
        state_nxt   = state;
        drop_nxt    = drop;
        cmd_nxt     = cmd_q;
        addr_nxt    = addr_q;
        data_nxt    = data_q;
        if_gnt_c    = 1'b0;
        dm_gnt_c    = 1'b0;
        if_rvalid_c = 1'b0;
        dm_rvalid_c = 1'b0;
        unique case (state)
            IDLE: begin
                drop_nxt = 1'b0;
                if (pick_dm) begin
                    dm_gnt_c  = 1'b1;
                    cmd_nxt   = dm_we ? CMD_STORE : CMD_LOAD;
                    addr_nxt  = dm_addr_al;
                    data_nxt  = dm_wdata;
                    state_nxt = DM_BUSY;
                end else if (pick_if) begin
                    if_gnt_c  = 1'b1;
                    cmd_nxt   = CMD_LOAD;
                    addr_nxt  = if_addr_al;
                    state_nxt = IF_BUSY;
                end
            end
            IF_BUSY: begin
                if (mem2proc_ack) begin
                    // A squashed fetch still has to drain; only its rvalid is hidden.
                    if_rvalid_c = ~drop & ~if_flush;
                    drop_nxt    = 1'b0;
                    cmd_nxt     = CMD_NONE;
                    state_nxt   = IDLE;
                end else if (if_flush) begin
                    drop_nxt = 1'b1;
                end
            end
            DM_BUSY: begin
                if (mem2proc_ack) begin
                    dm_rvalid_c = 1'b1;
                    cmd_nxt     = CMD_NONE;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                drop_nxt  = 1'b0;
                cmd_nxt   = CMD_NONE;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            drop   <= 1'b0;
            cmd_q  <= CMD_NONE;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state  <= state_nxt;
            drop   <= drop_nxt;
            cmd_q  <= cmd_nxt;
            addr_q <= addr_nxt;
            data_q <= data_nxt;
        end
    end

    // Grants are combinational, so keep them quiet while reset is held.
    assign if_gnt    = if_gnt_c & ~rst;
    assign dm_gnt    = dm_gnt_c & ~rst;
    assign if_rvalid = if_rvalid_c;
    assign dm_rvalid = dm_rvalid_c;
    assign if_rdata  = mem2proc_data;
    assign dm_rdata  = mem2proc_data;
    assign stall_if  = (if_req & ~if_rvalid_c) | drop;

    assign proc2mem_command = cmd_q;
    assign proc2mem_addr    = addr_q;
    assign proc2mem_data    = data_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed, table-driven bench for imem_dmem_arbiter.
// Hand sequence covers async reset mid-transaction.
module tb_imem_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_gnt;
    logic [31:0] if_rdata;
    logic        if_rvalid;
    logic        stall_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic [31:0] dm_rdata;
    logic        dm_rvalid;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [31:0] proc2mem_data;
    logic        mem2proc_ack;
    logic [31:0] mem2proc_data;

    int total = 0;
    int bad   = 0;

    imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
        .stall_if(stall_if),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rdata(dm_rdata),
        .dm_rvalid(dm_rvalid),
        .proc2mem_command(proc2mem_command),
        .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
        .mem2proc_ack(mem2proc_ack), .mem2proc_data(mem2proc_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dr;
        logic        we;
        logic [31:0] da;
        logic [31:0] dw;
        logic        ir;
        logic [31:0] ia;
        logic        fl;
        logic        ack;
        logic [31:0] md;
        logic        igt;
        logic        dgt;
        logic        irv;
        logic        drv;
        logic        stl;
        logic [1:0]  cmd;
        logic [31:0] pa;
        logic [31:0] pd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        logic dr, logic we, logic [31:0] da, logic [31:0] dw,
        logic ir, logic [31:0] ia, logic fl, logic ack, logic [31:0] md,
        logic igt, logic dgt, logic irv, logic drv, logic stl,
        logic [1:0] cmd, logic [31:0] pa, logic [31:0] pd);
        vec_t v;
        v.dr = dr;   v.we = we;   v.da = da;   v.dw = dw;
        v.ir = ir;   v.ia = ia;   v.fl = fl;   v.ack = ack;
        v.md = md;   v.igt = igt; v.dgt = dgt; v.irv = irv;
        v.drv = drv; v.stl = stl; v.cmd = cmd; v.pa = pa;
        v.pd = pd;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        dm_req        = v.dr;
        dm_we         = v.we;
        dm_addr       = v.da;
        dm_wdata      = v.dw;
        if_req        = v.ir;
        if_addr       = v.ia;
        if_flush      = v.fl;
        mem2proc_ack  = v.ack;
        mem2proc_data = v.md;
    endtask

    task automatic check_vec(vec_t v, int idx);
        string t;
        t = $sformatf("v%0d", idx);
        chk({t, ".if_gnt"},    {31'b0, if_gnt},    {31'b0, v.igt});
        chk({t, ".dm_gnt"},    {31'b0, dm_gnt},    {31'b0, v.dgt});
        chk({t, ".if_rvalid"}, {31'b0, if_rvalid}, {31'b0, v.irv});
        chk({t, ".dm_rvalid"}, {31'b0, dm_rvalid}, {31'b0, v.drv});
        chk({t, ".stall_if"},  {31'b0, stall_if},  {31'b0, v.stl});
        chk({t, ".command"},   {30'b0, proc2mem_command}, {30'b0, v.cmd});
        if (v.cmd != 2'd0)
            chk({t, ".addr"}, proc2mem_addr, v.pa);
        if (v.cmd == 2'd2)
            chk({t, ".wdata"}, proc2mem_data, v.pd);
        if (v.irv)
            chk({t, ".if_rdata"}, if_rdata, v.md);
        if (v.drv && v.cmd == 2'd1)
            chk({t, ".dm_rdata"}, dm_rdata, v.md);
    endtask

    initial begin
        vec_t z;
        z = mk(0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0);

        // Fetch 0x6, ack two cycles after grant
        vecs.push_back(mk(0,0,0,0, 1,'h6,0,0,0, 1,0,0,0,1, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,'h6,0,0,0, 0,0,0,0,1, 1,'h4,0));
        vecs.push_back(mk(0,0,0,0, 1,'h6,0,1,'hDEADBEEF, 0,0,1,0,0, 1,'h4,0));
        vecs.push_back(z);
        // Store wins over fetch, fetch follows the ack
        vecs.push_back(mk(1,1,'h100,'h12345678, 1,'h20,0,0,0, 0,1,0,0,1, 0,0,0));
        vecs.push_back(mk(1,1,'h100,'h12345678, 1,'h20,0,0,0, 0,0,0,0,1, 2,'h100,'h12345678));
        vecs.push_back(mk(1,1,'h100,'h12345678, 1,'h20,0,1,0, 0,0,0,1,1, 2,'h100,'h12345678));
        vecs.push_back(mk(0,0,0,0, 1,'h20,0,0,0, 1,0,0,0,1, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,'h20,0,1,'hA5A5A5A5, 0,0,1,0,0, 1,'h20,0));
        vecs.push_back(z);
        // Flush while fetch outstanding, ack three cycles later
        vecs.push_back(mk(0,0,0,0, 1,'h30,0,0,0, 1,0,0,0,1, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,'h30,1,0,0, 0,0,0,0,1, 1,'h30,0));
        vecs.push_back(mk(0,0,0,0, 1,'h40,0,0,0, 0,0,0,0,1, 1,'h30,0));
        vecs.push_back(mk(0,0,0,0, 1,'h40,0,0,0, 0,0,0,0,1, 1,'h30,0));
        vecs.push_back(mk(0,0,0,0, 1,'h40,0,1,'h0BAD0BAD, 0,0,0,0,1, 1,'h30,0));
        vecs.push_back(mk(0,0,0,0, 1,'h40,0,0,0, 1,0,0,0,1, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,'h40,0,1,'h11111111, 0,0,1,0,0, 1,'h40,0));
        // Flush in IDLE blocks grant; flush on the ack cycle hides rvalid
        vecs.push_back(mk(0,0,0,0, 1,'h50,1,0,0, 0,0,0,0,1, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,'h50,0,0,0, 1,0,0,0,1, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,'h50,1,1,'h22222222, 0,0,0,0,1, 1,'h50,0));
        vecs.push_back(z);
        // Back-to-back loads, flush in DM_BUSY ignored, ack in IDLE ignored
        vecs.push_back(mk(1,0,'h10,0, 0,0,0,0,0, 0,1,0,0,0, 0,0,0));
        vecs.push_back(mk(1,0,'h10,0, 0,0,1,1,'hAAAA0010, 0,0,0,1,0, 1,'h10,0));
        vecs.push_back(mk(1,0,'h14,0, 0,0,0,0,0, 0,1,0,0,0, 0,0,0));
        vecs.push_back(mk(1,0,'h14,0, 0,0,0,1,'hAAAA0014, 0,0,0,1,0, 1,'h14,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,1,'h5, 0,0,0,0,0, 0,0,0));
        vecs.push_back(z);
        // Both requests held: arbitration policy
        vecs.push_back(mk(1,0,'h200,0, 0,'h300,0,0,0, 0,1,0,0,0, 0,0,0));
        vecs.push_back(mk(1,0,'h200,0, 1,'h300,0,1,'hC0C0C0C0, 0,0,0,1,1, 1,'h200,0));
`ifdef ARB_RR_EN
        vecs.push_back(mk(1,0,'h200,0, 1,'h300,0,0,0, 1,0,0,0,1, 0,0,0));
        vecs.push_back(mk(1,0,'h200,0, 1,'h300,0,1,'hC1C1C1C1, 0,0,1,0,0, 1,'h300,0));
`else
        vecs.push_back(mk(1,0,'h200,0, 1,'h300,0,0,0, 0,1,0,0,1, 0,0,0));
        vecs.push_back(mk(1,0,'h200,0, 1,'h300,0,1,'hC1C1C1C1, 0,0,0,1,1, 1,'h200,0));
`endif
        vecs.push_back(mk(1,0,'h200,0, 1,'h300,0,0,0, 0,1,0,0,1, 0,0,0));
        vecs.push_back(mk(1,0,'h200,0, 1,'h300,0,1,'hC2C2C2C2, 0,0,0,1,1, 1,'h200,0));
        vecs.push_back(mk(0,0,'h200,0, 1,'h300,0,0,0, 1,0,0,0,1, 0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,'h300,0,1,'hC3C3C3C3, 0,0,1,0,0, 1,'h300,0));
        vecs.push_back(z);

        // Reset state, with a data request held during reset
        rst = 1'b1;
        drive(z);
        dm_req = 1'b1;
        dm_addr = 32'h40;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.command", {30'b0, proc2mem_command}, 32'd0);
        chk("rst.dm_gnt", {31'b0, dm_gnt}, 32'd0);
        chk("rst.if_gnt", {31'b0, if_gnt}, 32'd0);
        chk("rst.stall_if", {31'b0, stall_if}, 32'd0);
        chk("rst.dm_rvalid", {31'b0, dm_rvalid}, 32'd0);
        chk("rst.addr", proc2mem_addr, 32'd0);

        // Load to 0x40 granted, then reset before the ack
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rmid.dm_gnt", {31'b0, dm_gnt}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rmid.busy_cmd", {30'b0, proc2mem_command}, 32'd1);
        chk("rmid.busy_addr", proc2mem_addr, 32'h40);
        #1;
        rst = 1'b1;
        dm_req = 1'b0;
        #1;
        chk("rmid.async_cmd", {30'b0, proc2mem_command}, 32'd0);
        chk("rmid.async_rvalid", {31'b0, dm_rvalid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem2proc_ack = 1'b1;
        mem2proc_data = 32'hFFFF0040;
        @(negedge clk);
        chk("rmid.late_ack_rvalid", {31'b0, dm_rvalid}, 32'd0);
        chk("rmid.late_ack_cmd", {30'b0, proc2mem_command}, 32'd0);
        chk("rmid.late_ack_gnt", {31'b0, dm_gnt}, 32'd0);
        @(posedge clk); #1;
        drive(z);
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(negedge clk);
            check_vec(vecs[i], i);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
